// File: rtl/div64_seq.sv
// Iterative 64-bit restoring divider. One quotient bit per cycle through a
// single shared subtractor64. Signed operands are divided as magnitudes and
// the signs are restored in FIX (truncating division: remainder takes the
// dividend's sign).
//
// state | meaning
// IDLE  | waiting for start
// PREP  | form operand magnitudes and sign flags, or short-cut divide-by-zero
// ITER  | 64 shift/trial-subtract steps, counter 0..63
// FIX   | apply signs and publish quotient/remainder
// DONE  | done pulse; a new start is accepted here too

module subtractor64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [63:0] diff,
   output logic        cout,
   output logic        overflow
);
   logic [64:0] sum;

   // a - b as a + ~b + 1; carry out high means no borrow (a >= b unsigned)
   assign sum      = {1'b0, a} + {1'b0, ~b} + 65'd1;
   assign diff     = sum[63:0];
   assign cout     = sum[64];
   assign overflow = (a[63] ^ b[63]) & (a[63] ^ diff[63]);
endmodule

module div64_seq #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_ITER = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             sgn_q, sgn_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dz_q, dz_d;

   logic [WIDTH-1:0] sub_a;
   logic [WIDTH-1:0] sub_diff;
   logic             sub_cout;
   logic             sub_ovf_unused;
   logic             dvd_neg, dvs_neg, accept;

   // The shifted partial remainder S[63:0]; S[64] is rem_q[63]
   assign sub_a = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

   subtractor64 u_sub (
      .a        (sub_a),
      .b        (mag_q),
      .diff     (sub_diff),
      .cout     (sub_cout),
      .overflow (sub_ovf_unused)
   );

   assign dvd_neg = sgn_q & dvd_q[WIDTH-1];
   assign dvs_neg = sgn_q & dvs_q[WIDTH-1];
   // A set S[64] means S exceeds any 64-bit divisor, so the trial always fits
   assign accept  = rem_q[WIDTH-1] | sub_cout;

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      sgn_d       = sgn_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      mag_d       = mag_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dz_d        = dz_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_PREP;
               dvd_d   = dividend;
               dvs_d   = divisor;
               sgn_d   = is_signed;
               dz_d    = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PREP: begin
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            rem_d   = '0;
            quo_d   = dvd_neg ? -dvd_q : dvd_q;
            mag_d   = dvs_neg ? -dvs_q : dvs_q;
            cnt_d   = '0;
            if (dvs_q == '0) begin
               // Remainder reports the operand as given, not its magnitude
               state_d     = ST_DONE;
               quotient_d  = '1;
               remainder_d = dvd_q;
               dz_d        = 1'b1;
            end else begin
               state_d = ST_ITER;
            end
         end
         ST_ITER: begin
            rem_d = accept ? sub_diff : sub_a;
            quo_d = {quo_q[WIDTH-2:0], accept};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            quotient_d  = q_neg_q ? -quo_q : quo_q;
            remainder_d = r_neg_q ? -rem_q : rem_q;
            state_d     = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         sgn_q       <= 1'b0;
         rem_q       <= '0;
         quo_q       <= '0;
         mag_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         sgn_q       <= sgn_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         mag_q       <= mag_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dz_q        <= dz_d;
      end
   end

   assign busy        = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
   assign done        = (state_q == ST_DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dz_q;
endmodule

// File: tb/tb_div64_seq.sv
// Directed bench for div64_seq: hand-computed vectors, latency, start
// handling while busy, back-to-back start in DONE, and mid-operation reset.

module tb_div64_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [63:0] dividend = '0;
   logic [63:0] divisor = '0;
   logic        busy, done, div_by_zero;
   logic [63:0] quotient, remainder;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] prev_q = '0;
   logic [63:0] prev_r = '0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   div64_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // Caller is positioned 1ns after a rising edge; start is driven now.
   task automatic do_op(input string tag, input logic sgn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_q,
                        input logic [63:0] exp_r, input logic exp_dz,
                        input int exp_lat, input bit pulse_mid);
      int n;
      start     = 1'b1;
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      @(posedge clk); #1;
      start     = 1'b0;
      is_signed = ~sgn;
      dividend  = 64'hDEAD_BEEF_0BAD_F00D;
      divisor   = 64'h3;
      n = 1;
      chk({tag, ".busy_c1"}, {63'd0, busy}, 64'd1);
      chk({tag, ".dz_clear"}, {63'd0, div_by_zero}, 64'd0);
      chk({tag, ".q_held"}, quotient, prev_q);
      chk({tag, ".r_held"}, remainder, prev_r);
      while (done !== 1'b1 && n < 200) begin
         if (pulse_mid && (n == 10 || n == 40)) begin
            start     = 1'b1;
            dividend  = 64'd5;
            divisor   = 64'd1;
         end
         if (n == 30) chk({tag, ".q_stable"}, quotient, prev_q);
         @(posedge clk); #1;
         start = 1'b0;
         n++;
      end
      chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
      chk({tag, ".quotient"}, quotient, exp_q);
      chk({tag, ".remainder"}, remainder, exp_r);
      chk({tag, ".dz"}, {63'd0, div_by_zero}, {63'd0, exp_dz});
      chk({tag, ".busy_done"}, {63'd0, busy}, 64'd0);
      prev_q = exp_q;
      prev_r = exp_r;
   endtask

   task automatic idle(input string tag);
      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
      chk({tag, ".idle_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, ".q_keep"}, quotient, prev_q);
      chk({tag, ".r_keep"}, remainder, prev_r);
   endtask

   initial begin
      #2;
      chk("rst.busy", {63'd0, busy}, 64'd0);
      chk("rst.done", {63'd0, done}, 64'd0);
      chk("rst.q", quotient, 64'd0);
      chk("rst.r", remainder, 64'd0);
      chk("rst.dz", {63'd0, div_by_zero}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("u100_7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 67, 1'b0);
      idle("u100_7");
      do_op("sn100_7", 1'b1, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 67, 1'b0);
      idle("sn100_7");
      do_op("s100_n7", 1'b1, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2,
            64'd2, 1'b0, 67, 1'b0);
      idle("s100_n7");
      do_op("sn100_n7", 1'b1, -64'sd100, -64'sd7, 64'd14,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 67, 1'b0);
      idle("sn100_n7");
      do_op("u_max", 1'b0, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd1, 1'b0, 67, 1'b0);
      idle("u_max");
      do_op("s_ovf", 1'b1, 64'h8000_0000_0000_0000, ONES,
            64'h8000_0000_0000_0000, 64'd0, 1'b0, 67, 1'b0);
      idle("s_ovf");
      do_op("u_ones_16", 1'b0, ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 1'b0, 67, 1'b0);
      idle("u_ones_16");
      do_op("s_n1_16", 1'b1, ONES, 64'h10, 64'd0, ONES, 1'b0, 67, 1'b0);
      idle("s_n1_16");
      do_op("u_min_2", 1'b0, 64'h8000_0000_0000_0000, 64'd2,
            64'h4000_0000_0000_0000, 64'd0, 1'b0, 67, 1'b0);
      idle("u_min_2");

      do_op("dz_u", 1'b0, 64'h1234, 64'd0, ONES, 64'h1234, 1'b1, 2, 1'b0);
      idle("dz_u");
      do_op("dz_s", 1'b1, 64'h1234, 64'd0, ONES, 64'h1234, 1'b1, 2, 1'b0);
      idle("dz_s");
      do_op("dz_sneg", 1'b1, -64'sd5, 64'd0, ONES, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 2, 1'b0);
      // Back-to-back: start in the DONE cycle; div_by_zero must clear
      do_op("b2b_1", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 67, 1'b0);
      do_op("b2b_2", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 67, 1'b0);
      idle("b2b_2");

      do_op("ign_start", 1'b0, 64'd1000, 64'd33, 64'd30, 64'd10, 1'b0, 67, 1'b1);
      idle("ign_start");

      // Mid-operation reset at ITER counter 30
      do_op("pre_rst", 1'b0, 64'h55, 64'd0, ONES, 64'h55, 1'b1, 2, 1'b0);
      idle("pre_rst");
      start    = 1'b1;
      dividend = 64'd100;
      divisor  = 64'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (31) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst.busy", {63'd0, busy}, 64'd0);
      chk("mrst.done", {63'd0, done}, 64'd0);
      chk("mrst.q", quotient, 64'd0);
      chk("mrst.r", remainder, 64'd0);
      chk("mrst.dz", {63'd0, div_by_zero}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      prev_q = '0;
      prev_r = '0;
      chk("mrst.idle", {63'd0, busy}, 64'd0);
      do_op("post_rst", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 67, 1'b0);
      idle("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
